// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the receive deframer.
// Contents:
//   parity_e    - parity selection (NONE / EVEN / ODD)
//   rx_state_e  - receive FSM states
//   MIN_DIV_DEF - default smallest honoured clocks-per-bit
//   DATA_BITS   - data bits per frame
//   to_parity() - maps the 2-bit parity_mode input onto parity_e
package uart_pkg;

    localparam int unsigned MIN_DIV_DEF = 4;
    localparam int unsigned DATA_BITS   = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2,
        RX_BREAK
    } rx_state_e;

    // Mode 3 is reserved and behaves as no parity.
    function automatic parity_e to_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Received-byte stream with valid/ready handshake and per-byte status.
//   rx_data       - received byte, held while rx_valid
//   rx_valid      - byte available
//   rx_ready      - consumer takes the byte when rx_valid && rx_ready
//   rx_parity_err - parity mismatch, qualified by rx_valid
//   rx_frame_err  - a stop bit sampled low, qualified by rx_valid
// master: the deframer (producer); slave: the consumer.
interface uart_rx_deframer_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_parity_err;
    logic       rx_frame_err;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a registered
// falling-edge pulse.
//   clk  - clock
//   rst  - synchronous active-high reset (flops preset to line idle = 1)
//   rxd  - asynchronous serial input
//   line - synchronized line level
//   fall - one-cycle pulse, asserted in the same cycle line first reads 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic line,
    output logic fall
);

    logic meta;

    // fall compares the two stages before line updates, so the pulse and the
    // low line level appear together; the FSM then enters START 3 clk after
    // the line fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            line <= 1'b1;
            fall <= 1'b0;
        end else begin
            meta <= rxd;
            line <= meta;
            fall <= line & ~meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start, 8 data bits LSB first, optional even/odd
// parity, 1 or 2 stop bits, baud_div clocks per bit. Delivers bytes on a
// valid/ready interface with parity, framing and overrun status.
//   clk, rst    - clock, synchronous active-high reset
//   baud_div    - clocks per bit, clamped up to MIN_DIV
//   parity_mode - 0 none, 1 even, 2 odd, 3 none
//   stop_bits   - 0 one stop bit, 1 two stop bits
//   uart_rxd    - asynchronous serial input, idle high
//   rx          - byte stream (master side)
//   rx_overrun  - one-cycle pulse when a completed frame is dropped
//   rx_busy     - FSM is not idle
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud_div,
    input  logic [1:0]  parity_mode,
    input  logic        stop_bits,
    input  logic        uart_rxd,
    uart_rx_deframer_if.master rx,
    output logic        rx_overrun,
    output logic        rx_busy
);

    localparam logic [15:0] MIN_DIV16 = 16'(MIN_DIV);

    logic        line;
    logic        fall;
    rx_state_e   state;
    logic [15:0] cnt;
    logic [15:0] div_q;
    parity_e     par_q;
    logic        two_stop_q;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        perr;
    logic        ferr;

    logic [15:0] div_in;
    logic        cnt_zero;
    logic        last_stop;
    logic        ferr_fin;
    logic        can_load;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (uart_rxd),
        .line (line),
        .fall (fall)
    );

    always_comb begin
        div_in    = (baud_div < MIN_DIV16) ? MIN_DIV16 : baud_div;
        cnt_zero  = (cnt == 16'd0);
        // Sample of the final stop bit: the frame completes this cycle.
        last_stop = cnt_zero && ((state == RX_STOP2) ||
                                 (state == RX_STOP1 && !two_stop_q));
        ferr_fin  = ferr | ~line;
        can_load  = !rx.rx_valid || rx.rx_ready;
    end

    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RX_IDLE;
            cnt              <= '0;
            div_q            <= '0;
            par_q            <= PAR_NONE;
            two_stop_q       <= 1'b0;
            shreg            <= '0;
            bit_idx          <= '0;
            perr             <= 1'b0;
            ferr             <= 1'b0;
            rx.rx_data       <= '0;
            rx.rx_valid      <= 1'b0;
            rx.rx_parity_err <= 1'b0;
            rx.rx_frame_err  <= 1'b0;
            rx_overrun       <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx.rx_valid && rx.rx_ready)
                rx.rx_valid <= 1'b0;

            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        div_q      <= div_in;
                        par_q      <= to_parity(parity_mode);
                        two_stop_q <= stop_bits;
                        cnt        <= (div_in >> 1) - 16'd1;
                        bit_idx    <= '0;
                        perr       <= 1'b0;
                        ferr       <= 1'b0;
                        state      <= RX_START;
                    end
                end
                RX_START: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 16'd1;
                    end else if (line) begin
                        state <= RX_IDLE;          // false start
                    end else begin
                        cnt   <= div_q - 16'd1;
                        state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shreg   <= {line, shreg[7:1]};
                        cnt     <= div_q - 16'd1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1))
                            state <= (par_q != PAR_NONE) ? RX_PARITY : RX_STOP1;
                    end
                end
                RX_PARITY: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        perr  <= (par_q == PAR_EVEN) ? ^{shreg, line} : ~^{shreg, line};
                        cnt   <= div_q - 16'd1;
                        state <= RX_STOP1;
                    end
                end
                RX_STOP1, RX_STOP2: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 16'd1;
                    end else if (!last_stop) begin
                        ferr  <= ferr_fin;
                        cnt   <= div_q - 16'd1;
                        state <= RX_STOP2;
                    end
                end
                RX_BREAK: begin
                    // Hold off until the line idles so a stuck-low line
                    // cannot be read as a stream of start bits.
                    if (line)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase

            if (last_stop) begin
                if (can_load) begin
                    rx.rx_data       <= shreg;
                    rx.rx_parity_err <= perr;
                    rx.rx_frame_err  <= ferr_fin;
                    rx.rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
                state <= ferr_fin ? RX_BREAK : RX_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at baud_div=16.
module tb_uart_rx_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        uart_rxd;
    logic        rx_overrun;
    logic        rx_busy;

    uart_rx_deframer_if rx_if ();

    uart_rx_deframer dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .uart_rxd    (uart_rxd),
        .rx          (rx_if),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ov_cnt = 0;
    int rise_cnt = 0;
    int busy_cyc = 0;
    logic prev_v = 1'b0;
    logic [9:0] q[$];

    // Inputs change 1 time unit after posedge, so the negedge view matches
    // what the DUT sees at the following posedge.
    always @(negedge clk) begin
        if (rx_if.rx_valid && rx_if.rx_ready)
            q.push_back({rx_if.rx_frame_err, rx_if.rx_parity_err, rx_if.rx_data});
        if (rx_overrun) ov_cnt++;
        if (rx_if.rx_valid && !prev_v) rise_cnt++;
        if (rx_busy) busy_cyc++;
        prev_v = rx_if.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        tick(16);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic sb,
                        input logic bad_par, input logic stop_low);
        parity_mode = pm;
        stop_bits   = sb;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pm == 2'd1) drive_bit((^d) ^ bad_par);
        else if (pm == 2'd2) drive_bit((~^d) ^ bad_par);
        drive_bit(~stop_low);
        if (sb) drive_bit(~stop_low);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d,
                               input logic pe, input logic fe);
        logic [9:0] f;
        chk({tag, "_n"}, q.size(), 1);
        if (q.size() > 0) begin
            f = q.pop_front();
            chk({tag, "_data"}, f[7:0], d);
            chk({tag, "_perr"}, f[8], pe);
            chk({tag, "_ferr"}, f[9], fe);
        end
        q.delete();
    endtask

    initial begin
        int r0, o0, b0;
        rst = 1'b1;
        baud_div = 16'd16;
        parity_mode = 2'd0;
        stop_bits = 1'b0;
        uart_rxd = 1'b1;
        rx_if.rx_ready = 1'b1;
        tick(3);

        chk("rst_valid", rx_if.rx_valid, 0);
        chk("rst_data", rx_if.rx_data, 0);
        chk("rst_perr", rx_if.rx_parity_err, 0);
        chk("rst_ferr", rx_if.rx_frame_err, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ovr", rx_overrun, 0);
        rst = 1'b0;
        tick(4);
        chk("idle_busy", rx_busy, 0);

        // 0xA5, no parity, one stop
        r0 = rise_cnt;
        send(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(20);
        check_frame("t1", 8'hA5, 1'b0, 1'b0);
        chk("t1_rise", rise_cnt - r0, 1);
        chk("t1_valid_low", rx_if.rx_valid, 0);
        chk("t1_busy", rx_busy, 0);

        // 0x34, even parity driven wrong, two stop
        send(8'h34, 2'd1, 1'b1, 1'b1, 1'b0);
        tick(20);
        check_frame("t2", 8'h34, 1'b1, 1'b0);

        // 0x56, odd parity, stop low, line stuck low for 40 bits
        r0 = rise_cnt;
        send(8'h56, 2'd2, 1'b0, 1'b0, 1'b1);
        uart_rxd = 1'b0;
        tick(40 * 16);
        chk("t3_break_busy", rx_busy, 1);
        chk("t3_rise", rise_cnt - r0, 1);
        check_frame("t3", 8'h56, 1'b0, 1'b1);
        uart_rxd = 1'b1;
        tick(32);
        chk("t3_idle_busy", rx_busy, 0);
        chk("t3_no_more", q.size(), 0);
        send(8'h0F, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(20);
        check_frame("t3b", 8'h0F, 1'b0, 1'b0);

        // glitch: 4 clk low
        r0 = rise_cnt;
        b0 = busy_cyc;
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(40);
        chk("t4_busy_seen", (busy_cyc - b0) > 0, 1);
        chk("t4_no_valid", rise_cnt - r0, 0);
        chk("t4_busy_end", rx_busy, 0);

        // back-to-back with consumer stalled
        rx_if.rx_ready = 1'b0;
        r0 = rise_cnt;
        o0 = ov_cnt;
        send(8'h11, 2'd0, 1'b0, 1'b0, 1'b0);
        send(8'h22, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(4);
        chk("t5_valid", rx_if.rx_valid, 1);
        chk("t5_hold", rx_if.rx_data, 8'h11);
        chk("t5_ovr", ov_cnt - o0, 1);
        chk("t5_rise", rise_cnt - r0, 1);
        rx_if.rx_ready = 1'b1;
        tick(2);
        chk("t5_clear", rx_if.rx_valid, 0);
        check_frame("t5", 8'h11, 1'b0, 1'b0);

        // reset mid-DATA of 0xFF, then 0x3C
        parity_mode = 2'd0;
        stop_bits = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("t6_busy_pre", rx_busy, 1);
        rst = 1'b1;
        tick(2);
        chk("t6_busy_rst", rx_busy, 0);
        chk("t6_valid_rst", rx_if.rx_valid, 0);
        rst = 1'b0;
        uart_rxd = 1'b1;
        tick(16 * 8);
        chk("t6_no_out", q.size(), 0);
        chk("t6_busy_idle", rx_busy, 0);
        send(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(20);
        check_frame("t6", 8'h3C, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
